// File: rtl/asi_pkg.sv
// Shared encodings for the asi family: AXI burst/response codes and the
// read-side beat FSM state type.
package asi_pkg;

  localparam logic [1:0] BT_FIXED    = 2'b00;
  localparam logic [1:0] BT_INCR     = 2'b01;
  localparam logic [1:0] BT_WRAP     = 2'b10;
  localparam logic [1:0] BT_RESERVED = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, FIRST, BURST} state_t;

endpackage

// File: rtl/sfifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// DEPTH must be a power of two and at least 2; push when full and pop when empty are ignored.
module sfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/asi_r2.sv
// AXI4 slave read interface: AR queue, per-beat user read strobes, latency pipeline
// and credit-protected R buffer. Define ASI_R2_WRAP_EN to support WRAP bursts.
module asi_r2
  import asi_pkg::*;
#(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 40,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2,
  parameter int AXI_RRESPW = 2,
  parameter int ASI_AD     = 4,
  parameter int ASI_RD     = 16,
  parameter int SLV_WS     = 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [AXI_IW-1:0]     ARID,
  input  logic [AXI_AW-1:0]     ARADDR,
  input  logic [AXI_LW-1:0]     ARLEN,
  input  logic [AXI_SW-1:0]     ARSIZE,
  input  logic [AXI_BURSTW-1:0] ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [AXI_IW-1:0]     RID,
  output logic [AXI_DW-1:0]     RDATA,
  output logic [AXI_RRESPW-1:0] RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [AXI_AW-1:0]     usr_raddr,
  output logic                  usr_re,
  output logic                  usr_rlast,
  output logic [AXI_IW-1:0]     usr_rid,
  input  logic [AXI_DW-1:0]     usr_rdata,
  input  logic                  usr_rerror,
  output logic                  usr_rrequest,
  input  logic                  usr_rgrant,
  output state_t                dbg_state_o
);
  localparam int MAXSZ = $clog2(AXI_DW/8);
  localparam logic [AXI_SW-1:0] MAXSZ_W = AXI_SW'(MAXSZ);
  localparam int ARW = AXI_IW + AXI_AW + AXI_LW + AXI_SW + AXI_BURSTW;
  localparam int RBW = AXI_IW + 1 + AXI_RRESPW + AXI_DW;
  localparam int CW  = $clog2(ASI_RD) + 1;
  localparam int SBW = AXI_IW + 3;
  localparam int XW  = AXI_AW + 1;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never depends on ready, and a payload is held until it is accepted.
  state_t state_q, state_d;
  logic [AXI_IW-1:0]     id_q, h_id, cur_id;
  logic [AXI_AW-1:0]     addr_q, h_addr, cur_addr;
  logic [AXI_LW-1:0]     len_q, h_len, cur_len, cnt_q, cnt_d, beat_n;
  logic [AXI_SW-1:0]     size_q, h_size, cur_size;
  logic [AXI_BURSTW-1:0] burst_q, h_burst, cur_burst;
  logic [ARW-1:0]        ar_dout;
  logic [$clog2(ASI_AD):0] ar_cnt;
  logic                  ar_empty, ar_pop, latch;
  logic [CW-1:0]         rb_cnt, inflight_q;
  logic [CW:0]           occ;
  logic                  active, issue, is_last, sup, bad_burst;
  logic [XW-1:0]         start_w, amask_w, aligned_w, step_w, beat_addr;

  sfifo #(.W(ARW), .DEPTH(ASI_AD)) u_ar_q (
    .clk_i(ACLK), .rst_ni(ARESETn), .push_i(ARVALID && ARREADY),
    .din_i({ARID, ARADDR, ARLEN, ARSIZE, ARBURST}), .pop_i(ar_pop),
    .dout_o(ar_dout), .count_o(ar_cnt)
  );

  assign ARREADY  = ARESETn && (ar_cnt != (($clog2(ASI_AD)+1))'(ASI_AD));
  assign ar_empty = (ar_cnt == '0);
  assign {h_id, h_addr, h_len, h_size, h_burst} = ar_dout;

  // Beat 0 is taken straight from the queue head; later beats use the latched copy.
  always_comb begin
    if (state_q == FIRST) begin
      {cur_id, cur_addr, cur_len, cur_size, cur_burst} = {h_id, h_addr, h_len, h_size, h_burst};
      beat_n = '0;
    end else begin
      {cur_id, cur_addr, cur_len, cur_size, cur_burst} = {id_q, addr_q, len_q, size_q, burst_q};
      beat_n = cnt_q;
    end
  end

  assign occ      = {1'b0, rb_cnt} + {1'b0, inflight_q};
  assign active   = ((state_q == FIRST) && !ar_empty) || (state_q == BURST);
  assign issue    = active && usr_rgrant && (occ < (CW+1)'(ASI_RD));
  assign is_last  = (beat_n == cur_len);

  assign start_w   = {1'b0, cur_addr};
  assign amask_w   = {XW{1'b1}} << cur_size;
  assign aligned_w = start_w & amask_w;
  assign step_w    = XW'(beat_n) << cur_size;

`ifdef ASI_R2_WRAP_EN
  logic [XW-1:0] wmask_w, wrap_addr;
  logic          wrap_ok;
  assign wmask_w   = ((XW'(cur_len) + 1'b1) << cur_size) - 1'b1;
  assign wrap_addr = (start_w & ~wmask_w) | ((start_w + step_w) & wmask_w);
  assign wrap_ok   = ((cur_len == AXI_LW'(1)) || (cur_len == AXI_LW'(3)) ||
                      (cur_len == AXI_LW'(7)) || (cur_len == AXI_LW'(15))) &&
                     ((start_w & ~amask_w) == '0);
`endif

  always_comb begin
    beat_addr = aligned_w + step_w;
    bad_burst = 1'b0;
    case (cur_burst)
      BT_FIXED: beat_addr = start_w;
      BT_INCR:  beat_addr = aligned_w + step_w;
`ifdef ASI_R2_WRAP_EN
      BT_WRAP: begin
        beat_addr = wrap_addr;
        bad_burst = !wrap_ok;
      end
`endif
      default:  bad_burst = 1'b1;
    endcase
    // Incrementing beats past the 4KB page of the start address are refused.
    sup = bad_burst || (cur_size > MAXSZ_W) ||
          ((cur_burst == BT_INCR) && (beat_addr[XW-1:12] != start_w[XW-1:12]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ar_pop  = 1'b0;
    latch   = 1'b0;
    case (state_q)
      IDLE:  state_d = FIRST;
      FIRST: if (issue) begin
        ar_pop = 1'b1;
        if (cur_len != '0) begin
          latch   = 1'b1;
          cnt_d   = AXI_LW'(1);
          state_d = BURST;
        end
      end
      BURST: if (issue) begin
        cnt_d = cnt_q + 1'b1;
        if (is_last) state_d = FIRST;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      {id_q, addr_q, len_q, size_q, burst_q} <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) {id_q, addr_q, len_q, size_q, burst_q} <= {h_id, h_addr, h_len, h_size, h_burst};
    end
  end

  assign usr_rrequest = ((state_q == FIRST) && !ar_empty) || (state_q == BURST);
  assign usr_re       = issue && !sup;
  assign usr_rlast    = usr_re && is_last;
  assign usr_raddr    = usr_re ? beat_addr[AXI_AW-1:0] : '0;
  assign usr_rid      = issue ? cur_id : '0;
  assign dbg_state_o  = state_q;

  logic [SBW-1:0]    sb_out;
  logic              p_v, p_last, p_sup;
  logic [AXI_IW-1:0] p_id;

  generate
    if (SLV_WS == 0) begin : g_nopipe
      assign sb_out = {issue, cur_id, is_last, sup};
    end else begin : g_pipe
      logic [SBW-1:0] pipe_q [SLV_WS];
      always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
          for (int i = 0; i < SLV_WS; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= {issue, cur_id, is_last, sup};
          for (int i = 1; i < SLV_WS; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign sb_out = pipe_q[SLV_WS-1];
    end
  endgenerate

  assign {p_v, p_id, p_last, p_sup} = sb_out;

  // Beats between issue and R buffer write still hold a credit.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) inflight_q <= '0;
    else inflight_q <= inflight_q + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, p_v};
  end

  logic [RBW-1:0]        rb_dout;
  logic [AXI_IW-1:0]     rb_id;
  logic                  rb_last;
  logic [AXI_RRESPW-1:0] rb_resp;
  logic [AXI_DW-1:0]     rb_data;

  sfifo #(.W(RBW), .DEPTH(ASI_RD)) u_r_buf (
    .clk_i(ACLK), .rst_ni(ARESETn), .push_i(p_v),
    .din_i({p_id, p_last, (p_sup || usr_rerror) ? RESP_SLVERR : RESP_OKAY,
            p_sup ? {AXI_DW{1'b0}} : usr_rdata}),
    .pop_i(RVALID && RREADY), .dout_o(rb_dout), .count_o(rb_cnt)
  );

  assign {rb_id, rb_last, rb_resp, rb_data} = rb_dout;
  assign RVALID = (rb_cnt != '0);
  assign RID    = RVALID ? rb_id   : '0;
  assign RLAST  = RVALID && rb_last;
  assign RRESP  = RVALID ? rb_resp : '0;
  assign RDATA  = RVALID ? rb_data : '0;

endmodule

// File: tb/tb_asi_r2.sv
// Bench for asi_r2: reset/latency/credit/reset-mid-burst sequences, a burst table
// and randomized traffic, all checked against a burst-level reference model.
module tb_asi_r2;
  import asi_pkg::*;

  localparam int WS = 1;
  localparam int MAXSZ = 4;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic [7:0]   ARID = '0;
  logic [39:0]  ARADDR = '0;
  logic [7:0]   ARLEN = '0;
  logic [2:0]   ARSIZE = '0;
  logic [1:0]   ARBURST = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [7:0]   RID;
  logic [127:0] RDATA;
  logic [1:0]   RRESP;
  logic         RLAST, RVALID;
  logic         RREADY = 1'b1;
  logic [39:0]  usr_raddr;
  logic         usr_re, usr_rlast, usr_rrequest;
  logic [7:0]   usr_rid;
  logic [127:0] usr_rdata = '0;
  logic         usr_rerror = 1'b0;
  logic         usr_rgrant = 1'b1;
  state_t       dbg_state_o;

  asi_r2 #(.SLV_WS(WS)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .usr_raddr(usr_raddr), .usr_re(usr_re), .usr_rlast(usr_rlast), .usr_rid(usr_rid),
    .usr_rdata(usr_rdata), .usr_rerror(usr_rerror), .usr_rrequest(usr_rrequest),
    .usr_rgrant(usr_rgrant), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking core ----------------
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] mem_data(input logic [39:0] a);
    return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0], {a[7:0], a[39:16]}, a[31:0] + 32'h1234_5678};
  endfunction
  function automatic logic mem_err(input logic [39:0] a);
    return a[11:4] == 8'h7E;
  endfunction

  // ---------------- user memory responder ----------------
  logic [40:0] re_cap = '0;
  logic [40:0] rsp_pipe [WS];
  initial for (int i = 0; i < WS; i++) rsp_pipe[i] = '0;
  always @(negedge ACLK) re_cap = {usr_re, usr_raddr};
  always @(posedge ACLK) begin
    #1;
    for (int i = WS - 1; i > 0; i--) rsp_pipe[i] = rsp_pipe[i-1];
    rsp_pipe[0] = re_cap;
    if (rsp_pipe[WS-1][40]) begin
      usr_rdata  = mem_data(rsp_pipe[WS-1][39:0]);
      usr_rerror = mem_err(rsp_pipe[WS-1][39:0]);
    end else begin
      usr_rdata  = {$urandom, $urandom, $urandom, $urandom};
      usr_rerror = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [48:0]  exp_re_q[$];   // {id, last, addr}
  logic [138:0] exp_r_q[$];    // {id, last, resp, data}

  task automatic model_ar(input logic [7:0] id, input logic [39:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    longint unsigned a0, inc, nb, wl, ba;
    logic [39:0] b;
    bit all_bad, sup, last;
    a0 = 64'(addr); inc = 64'd1 << size; nb = 64'(len) + 1; wl = nb * inc;
    all_bad = (size > MAXSZ) || (burst == 2'b11);
    if (burst == 2'b10) begin
`ifdef ASI_R2_WRAP_EN
      if (!(len == 1 || len == 3 || len == 7 || len == 15) || (a0 % inc) != 0) all_bad = 1;
`else
      all_bad = 1;
`endif
    end
    for (longint unsigned n = 0; n < nb; n++) begin
      case (burst)
        2'b00:   ba = a0;
        2'b01:   ba = (a0 / inc) * inc + n * inc;
        default: ba = (a0 / wl) * wl + (a0 + n * inc) % wl;
      endcase
      b    = ba[39:0];
      sup  = all_bad || (burst == 2'b01 && ba[12] != a0[12]);
      last = (n == nb - 1);
      if (!sup) exp_re_q.push_back({id, last, b});
      exp_r_q.push_back({id, last, (sup || mem_err(b)) ? 2'b10 : 2'b00, sup ? 128'h0 : mem_data(b)});
    end
  endtask

  int row_re = 0, row_err = 0, row_rbeats = 0, row_rlast = 0;
  logic [39:0] row_a0 = '0, row_alast = '0;
  int re_cyc[2];

  task automatic clear_row();
    row_re = 0; row_err = 0; row_rbeats = 0; row_rlast = 0; row_a0 = '0; row_alast = '0;
    re_cyc[0] = 0; re_cyc[1] = 0;
  endtask

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      exp_re_q.delete();
      exp_r_q.delete();
    end else begin
      if (ARVALID && ARREADY) model_ar(ARID, ARADDR, ARLEN, ARSIZE, ARBURST);
      if (usr_re) begin
        if (exp_re_q.size() == 0) chk("usr_re_unexpected", {usr_rid, usr_rlast, usr_raddr}, 49'h0);
        else chk("usr_beat", {usr_rid, usr_rlast, usr_raddr}, exp_re_q.pop_front());
        if (row_re < 2) re_cyc[row_re] = cyc;
        if (row_re == 0) row_a0 = usr_raddr;
        row_alast = usr_raddr;
        row_re++;
      end
      if (RVALID && RREADY) begin
        if (exp_r_q.size() == 0) chk("r_unexpected", {RID, RLAST, RRESP, RDATA}, 139'h0);
        else chk("r_beat", {RID, RLAST, RRESP, RDATA}, exp_r_q.pop_front());
        row_rbeats++;
        if (RRESP == 2'b10) row_err++;
        if (RLAST) row_rlast++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [39:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge ACLK);
      done = ARREADY;
      tick();
    end
    if (!done) chk("ar_handshake_timeout", 0, 1);
    ARVALID = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge ACLK);
      done = (exp_re_q.size() == 0) && (exp_r_q.size() == 0) && !RVALID;
    end
    chk("drain", 256'(done), 1);
    tick();
  endtask

  // ---------------- burst table ----------------
  typedef struct {
    logic [39:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    int exp_re; int exp_err; logic [39:0] exp_a0; logic [39:0] exp_alast;
  } row_t;
  row_t rows[10];

  initial begin
    rows[0] = '{40'h1000, 8'd3, 3'd4, BT_INCR,     4, 0, 40'h1000, 40'h1030};
`ifdef ASI_R2_WRAP_EN
    rows[1] = '{40'h1030, 8'd3, 3'd4, BT_WRAP,     4, 0, 40'h1030, 40'h1020};
    rows[2] = '{40'h6040, 8'd7, 3'd4, BT_WRAP,     8, 0, 40'h6040, 40'h6030};
`else
    rows[1] = '{40'h1030, 8'd3, 3'd4, BT_WRAP,     0, 4, 40'h0,    40'h0};
    rows[2] = '{40'h6040, 8'd7, 3'd4, BT_WRAP,     0, 8, 40'h0,    40'h0};
`endif
    rows[3] = '{40'h1FE0, 8'd3, 3'd4, BT_INCR,     2, 2, 40'h1FE0, 40'h1FF0};
    rows[4] = '{40'h2000, 8'd1, 3'd5, BT_INCR,     0, 2, 40'h0,    40'h0};
    rows[5] = '{40'h3004, 8'd2, 3'd2, BT_FIXED,    3, 0, 40'h3004, 40'h3004};
    rows[6] = '{40'h27E0, 8'd0, 3'd4, BT_INCR,     1, 1, 40'h27E0, 40'h27E0};
    rows[7] = '{40'h5000, 8'd0, 3'd4, BT_RESERVED, 0, 1, 40'h0,    40'h0};
    rows[8] = '{40'h1000, 8'd2, 3'd4, BT_WRAP,     0, 3, 40'h0,    40'h0};
    rows[9] = '{40'h4003, 8'd2, 3'd0, BT_INCR,     3, 0, 40'h4003, 40'h4005};
  end

  // ---------------- main sequence ----------------
  initial begin
    bit stop;
    int rv_cnt;
    // reset values
    repeat (3) @(negedge ACLK);
    chk("rst_arready", 256'(ARREADY), 0);
    chk("rst_r", {RVALID, RLAST, RID, RRESP, RDATA}, 0);
    chk("rst_usr", {usr_re, usr_rrequest, usr_rlast, usr_raddr}, 0);
    chk("rst_state", 256'(dbg_state_o), 256'(IDLE));
    tick();
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("arready_after_rst", 256'(ARREADY), 1);
    tick();

    // first-transaction latency
    clear_row();
    ARVALID = 1'b1; ARID = 8'h11; ARADDR = 40'h700; ARLEN = 0; ARSIZE = 3'd4; ARBURST = BT_INCR;
    @(negedge ACLK);
    chk("lat_arready", 256'(ARREADY), 1);
    tick();
    ARVALID = 1'b0;
    @(negedge ACLK);
    chk("lat_usr_re_c1", 256'(usr_re), 1);
    for (int k = 0; k < WS; k++) @(negedge ACLK);
    chk("lat_rvalid_early", 256'(RVALID), 0);
    @(negedge ACLK);
    chk("lat_rvalid", 256'(RVALID), 1);
    wait_drain();

    // table-driven bursts
    for (int i = 0; i < 10; i++) begin
      clear_row();
      send_ar(8'(i), rows[i].addr, rows[i].len, rows[i].size, rows[i].burst);
      wait_drain();
      chk($sformatf("row%0d_re", i), 256'(row_re), 256'(rows[i].exp_re));
      chk($sformatf("row%0d_slverr", i), 256'(row_err), 256'(rows[i].exp_err));
      chk($sformatf("row%0d_rbeats", i), 256'(row_rbeats), 256'(rows[i].len) + 1);
      chk($sformatf("row%0d_rlast", i), 256'(row_rlast), 1);
      if (rows[i].exp_re > 0) begin
        chk($sformatf("row%0d_addr0", i), 256'(row_a0), 256'(rows[i].exp_a0));
        chk($sformatf("row%0d_addrN", i), 256'(row_alast), 256'(rows[i].exp_alast));
      end
    end

    // back-to-back single-beat bursts
    clear_row();
    send_ar(8'h21, 40'h800, 0, 3'd4, BT_INCR);
    send_ar(8'h22, 40'h900, 0, 3'd4, BT_INCR);
    wait_drain();
    chk("b2b_re", 256'(row_re), 2);
    chk("b2b_gap", 256'(re_cyc[1] - re_cyc[0]), 1);

    // credit stall with RREADY low
    clear_row();
    RREADY = 1'b0;
    send_ar(8'h33, 40'h8000, 8'd31, 3'd4, BT_INCR);
    repeat (40) tick();
    chk("credit_stall_re", 256'(row_re), 16);
    chk("credit_stall_rbeats", 256'(row_rbeats), 0);
    RREADY = 1'b1;
    wait_drain();
    chk("credit_total_re", 256'(row_re), 32);
    chk("credit_total_r", 256'(row_rbeats), 32);

    // reset in the middle of a 16-beat burst
    clear_row();
    send_ar(8'h44, 40'h9000, 8'd15, 3'd4, BT_INCR);
    stop = 0;
    for (int i = 0; i < 100 && !stop; i++) begin
      @(negedge ACLK);
      stop = (row_re >= 5);
    end
    chk("mid_rst_reach_beat5", 256'(stop), 1);
    tick();
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_arready_low", 256'(ARREADY), 0);
    tick();
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("mid_rst_rvalid", 256'(RVALID), 0);
    chk("mid_rst_arready", 256'(ARREADY), 1);
    rv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (RVALID || usr_re) rv_cnt++;
    end
    chk("mid_rst_quiet", 256'(rv_cnt), 0);
    tick();

    // randomized traffic
    stop = 0;
    fork
      begin
        for (int t = 0; t < 60; t++) begin
          logic [1:0] bt;
          logic [7:0] ln;
          logic [2:0] sz;
          logic [39:0] ad;
          bt = 2'($urandom_range(0, 3));
          sz = ($urandom_range(0, 7) == 0) ? 3'd5 : 3'($urandom_range(0, 4));
          if (bt == BT_WRAP && $urandom_range(0, 4) != 0) ln = 8'((2 << $urandom_range(0, 3)) - 1);
          else ln = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 7));
          ad = {8'h0, $urandom} & ({40{1'b1}} << sz);
          send_ar(8'($urandom), ad, ln, sz, bt);
          repeat ($urandom_range(0, 3)) tick();
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          tick();
          usr_rgrant = ($urandom_range(0, 3) != 0);
          RREADY = ($urandom_range(0, 9) < 7);
        end
      end
    join
    usr_rgrant = 1'b1;
    RREADY = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
